// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard_pkg
// Purpose  : Shared constants and types for the register file / scoreboard.
//            Holds the register address width, register count and the width
//            and saturation value of the per-register pending counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam int SB_CNT_W   = 2;
  localparam int SB_CNT_MAX = 3;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_counter.sv
`default_nettype none
// ============================================================================
// Module   : sb_counter
// Purpose  : Clamped up/down pending-write counter for one register.
//            Next = count + inc - dec; clamps at 0 (flagging underflow) and
//            never exceeds SB_CNT_MAX.
// Ports    : clk       - clock, rising edge
//            reset     - asynchronous active-low reset
//            inc       - one new in-flight writer this cycle
//            dec[1:0]  - writers retiring/cancelled this cycle (0..2)
//            count     - current pending count (registered)
//            underflow - combinational: dec exceeds count + inc this cycle
// Revision : 1.0 - initial release
// ============================================================================
module sb_counter
  import regfile_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic [1:0] dec,
  output sb_cnt_t    count,
  output logic       underflow
);

  sb_cnt_t    r_count;
  logic [2:0] w_sum;
  logic [2:0] w_next;

  always_comb begin
    w_sum     = {1'b0, r_count} + {2'b00, inc};
    underflow = ({1'b0, dec} > w_sum);
    if (underflow) begin
      w_next = 3'd0;
    end else begin
      w_next = w_sum - {1'b0, dec};
    end
    // Issue is blocked at saturation, so this clamp only guards the encoding.
    if (w_next > 3'(SB_CNT_MAX)) begin
      w_next = 3'(SB_CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next[SB_CNT_W-1:0];
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Architectural register file with same-cycle writeback bypass and
//            a per-register pending-write scoreboard driving the decode stall.
// Ports    : clk, reset              - clock / async active-low reset
//            regWrite_W, writeReg_W,
//            result_W                - writeback port
//            readReg1_D, readReg2_D  - decode source addresses
//            useRs_D, useRt_D        - sources actually consumed
//            issue_D, destReg_D      - decode destination being issued
//            cancel_X, cancelReg_X   - squashed writer, releases its slot
//            readData1_D/2_D         - operand data (combinational)
//            stall_D                 - decode must hold (combinational)
//            sbError                 - sticky scoreboard underflow flag
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int width    = 32,
  parameter int regCount = REG_COUNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regWrite_W,
  input  logic [REG_ADDR_W-1:0] writeReg_W,
  input  logic [width-1:0]      result_W,
  input  logic [REG_ADDR_W-1:0] readReg1_D,
  input  logic [REG_ADDR_W-1:0] readReg2_D,
  input  logic                  useRs_D,
  input  logic                  useRt_D,
  input  logic                  issue_D,
  input  logic [REG_ADDR_W-1:0] destReg_D,
  input  logic                  cancel_X,
  input  logic [REG_ADDR_W-1:0] cancelReg_X,
  output logic [width-1:0]      readData1_D,
  output logic [width-1:0]      readData2_D,
  output logic                  stall_D,
  output logic                  sbError
);

  logic [width-1:0]          r_regs [regCount];
  sb_cnt_t                   w_count [regCount];
  logic [regCount-1:0][1:0]  w_dec;
  logic [regCount-1:0]       w_underflow;
  logic                      w_issueOk;
  logic                      w_pend1;
  logic                      w_pend2;
  logic                      w_destFull;
  logic                      w_stall;
  logic                      r_sbError;

  // Register 0: constant zero, no counter.
  assign r_regs[0]      = '0;
  assign w_count[0]     = '0;
  assign w_dec[0]       = 2'b00;
  assign w_underflow[0] = 1'b0;

  generate
    for (genvar r = 1; r < regCount; r++) begin : g_reg
      logic w_wbHit;
      logic w_cancelHit;

      assign w_wbHit     = regWrite_W && (writeReg_W == REG_ADDR_W'(r));
      assign w_cancelHit = cancel_X && (cancelReg_X == REG_ADDR_W'(r));
      assign w_dec[r]    = {1'b0, w_wbHit} + {1'b0, w_cancelHit};

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_regs[r] <= '0;
        end else if (w_wbHit) begin
          r_regs[r] <= result_W;
        end
      end

      sb_counter u_sbCounter (
        .clk       (clk),
        .reset     (reset),
        .inc       (w_issueOk && (destReg_D == REG_ADDR_W'(r))),
        .dec       (w_dec[r]),
        .count     (w_count[r]),
        .underflow (w_underflow[r])
      );
    end
  endgenerate

  // Read with writeback bypass; address 0 is hard zero.
  always_comb begin
    readData1_D = r_regs[readReg1_D];
    if (readReg1_D == '0) begin
      readData1_D = '0;
    end else if (regWrite_W && (writeReg_W == readReg1_D)) begin
      readData1_D = result_W;
    end

    readData2_D = r_regs[readReg2_D];
    if (readReg2_D == '0) begin
      readData2_D = '0;
    end else if (regWrite_W && (writeReg_W == readReg2_D)) begin
      readData2_D = result_W;
    end
  end

  // Effective pending = count - dec (clamped) > 0, i.e. count > dec. A writer
  // retiring this cycle releases its consumer immediately via the bypass.
  assign w_pend1    = {1'b0, w_count[readReg1_D]} > {1'b0, w_dec[readReg1_D]};
  assign w_pend2    = {1'b0, w_count[readReg2_D]} > {1'b0, w_dec[readReg2_D]};
  // Saturation guard looks at the raw count so the increment can never wrap.
  assign w_destFull = (destReg_D != '0) &&
                      (w_count[destReg_D] == sb_cnt_t'(SB_CNT_MAX));

  assign w_stall   = (useRs_D && w_pend1) || (useRt_D && w_pend2) ||
                     (issue_D && w_destFull);
  assign w_issueOk = issue_D && !w_stall && (destReg_D != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sbError <= 1'b0;
    end else if (|w_underflow) begin
      r_sbError <= 1'b1;
    end
  end

  assign stall_D = w_stall;
  assign sbError = r_sbError;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Self-checking bench for regfile_scoreboard: directed scenarios
//            followed by random traffic, all checked against an array-based
//            model of register contents and outstanding-writer counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite_W;
  logic [4:0]  writeReg_W;
  logic [31:0] result_W;
  logic [4:0]  readReg1_D;
  logic [4:0]  readReg2_D;
  logic        useRs_D;
  logic        useRt_D;
  logic        issue_D;
  logic [4:0]  destReg_D;
  logic        cancel_X;
  logic [4:0]  cancelReg_X;
  logic [31:0] readData1_D;
  logic [31:0] readData2_D;
  logic        stall_D;
  logic        sbError;

  regfile_scoreboard #(.width(32), .regCount(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .regWrite_W  (regWrite_W),
    .writeReg_W  (writeReg_W),
    .result_W    (result_W),
    .readReg1_D  (readReg1_D),
    .readReg2_D  (readReg2_D),
    .useRs_D     (useRs_D),
    .useRt_D     (useRt_D),
    .issue_D     (issue_D),
    .destReg_D   (destReg_D),
    .cancel_X    (cancel_X),
    .cancelReg_X (cancelReg_X),
    .readData1_D (readData1_D),
    .readData2_D (readData2_D),
    .stall_D     (stall_D),
    .sbError     (sbError)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents and number of outstanding writers.
  logic [31:0] mReg [32];
  int          mCnt [32];
  bit          mErr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int decOf(input int r);
    int d = 0;
    if (r == 0) return 0;
    if (regWrite_W && int'(writeReg_W) == r) d++;
    if (cancel_X && int'(cancelReg_X) == r) d++;
    return d;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (regWrite_W && writeReg_W == a) return result_W;
    return mReg[a];
  endfunction

  function automatic bit busy(input logic [4:0] a);
    int e = mCnt[a] - decOf(int'(a));
    return (a != 0) && (e > 0);
  endfunction

  function automatic bit expStall();
    return (useRs_D && busy(readReg1_D)) || (useRt_D && busy(readReg2_D)) ||
           (issue_D && destReg_D != 0 && mCnt[destReg_D] == 3);
  endfunction

  task automatic clearModel();
    for (int r = 0; r < 32; r++) begin
      mReg[r] = 32'h0;
      mCnt[r] = 0;
    end
    mErr = 1'b0;
  endtask

  task automatic setIdle();
    regWrite_W = 0; writeReg_W = 0; result_W = 0;
    readReg1_D = 0; readReg2_D = 0; useRs_D = 0; useRt_D = 0;
    issue_D = 0; destReg_D = 0; cancel_X = 0; cancelReg_X = 0;
  endtask

  // Inputs are set at the falling edge; check just after, then advance one
  // rising edge and apply the same cycle to the model.
  task automatic step(input string tag);
    bit s;
    #1;
    s = expStall();
    chk({tag, ":rd1"},   readData1_D,   expRead(readReg1_D));
    chk({tag, ":rd2"},   readData2_D,   expRead(readReg2_D));
    chk({tag, ":stall"}, 32'(stall_D),  32'(s));
    chk({tag, ":err"},   32'(sbError),  32'(mErr));
    @(posedge clk);
    for (int r = 1; r < 32; r++) begin
      int n = mCnt[r] - decOf(r);
      if (issue_D && !s && int'(destReg_D) == r) n = n + 1;
      if (n < 0) begin
        n = 0;
        mErr = 1'b1;
      end
      mCnt[r] = n;
    end
    if (regWrite_W && writeReg_W != 0) mReg[writeReg_W] = result_W;
    @(negedge clk);
  endtask

  task automatic doReset();
    setIdle();
    readReg1_D = 5;
    readReg2_D = 9;
    reset = 1'b0;
    #2;
    chk("rst:rd1",   readData1_D, 32'h0);
    chk("rst:rd2",   readData2_D, 32'h0);
    chk("rst:stall", 32'(stall_D), 32'h0);
    chk("rst:err",   32'(sbError), 32'h0);
    clearModel();
    @(negedge clk);
    reset = 1'b1;
    step("postrst");
  endtask

  initial begin
    logic [4:0] pendQ[$];
    clearModel();
    setIdle();
    reset = 1'b0;
    @(negedge clk);
    doReset();

    // Write and same-cycle bypass.
    regWrite_W = 1; writeReg_W = 5; result_W = 32'hDEADBEEF; readReg1_D = 5;
    #1 chk("bypass", readData1_D, 32'hDEADBEEF);
    step("wr5");
    setIdle(); readReg1_D = 5;
    #1 chk("stored5", readData1_D, 32'hDEADBEEF);
    step("rd5");
    regWrite_W = 1; writeReg_W = 0; result_W = 32'h1234; readReg1_D = 0;
    step("wr0");
    setIdle(); readReg1_D = 0; readReg2_D = 5;
    #1 chk("rd0", readData1_D, 32'h0);
    step("rd0b");

    // Mid-run reset wipes storage and the sticky error from the writes above.
    doReset();
    setIdle(); readReg1_D = 5;
    #1 chk("rd5_after_rst", readData1_D, 32'h0);
    step("rd5r");

    // RAW hazard on reg 7.
    setIdle(); issue_D = 1; destReg_D = 7;
    step("iss7");
    setIdle(); useRs_D = 1; readReg1_D = 7;
    #1 chk("raw_stall", 32'(stall_D), 32'h1);
    step("raw1");
    step("raw2");
    regWrite_W = 1; writeReg_W = 7; result_W = 32'hCAFE0007;
    #1 chk("raw_release", 32'(stall_D), 32'h0);
    chk("raw_data", readData1_D, 32'hCAFE0007);
    step("ret7");
    setIdle(); issue_D = 1; destReg_D = 7;
    step("iss7b");
    setIdle(); useRs_D = 0; readReg1_D = 7;
    #1 chk("nouse_nostall", 32'(stall_D), 32'h0);
    step("nouse");
    regWrite_W = 1; writeReg_W = 7; result_W = 32'h77;
    step("ret7b");

    // Three writers to reg 9 saturate the counter.
    setIdle(); issue_D = 1; destReg_D = 9;
    step("iss9a");
    step("iss9b");
    step("iss9c");
    #1 chk("sat_stall", 32'(stall_D), 32'h1);
    step("iss9d");
    setIdle(); regWrite_W = 1; writeReg_W = 9; result_W = 32'h91;
    step("ret9a");
    issue_D = 1; destReg_D = 9; result_W = 32'h92;
    step("issret9");
    setIdle(); regWrite_W = 1; writeReg_W = 9; result_W = 32'h93;
    useRs_D = 1; readReg1_D = 9;
    #1 chk("hold_stall", 32'(stall_D), 32'h1);
    step("ret9b");
    result_W = 32'h94;
    #1 chk("last_release", 32'(stall_D), 32'h0);
    step("ret9c");
    setIdle(); useRt_D = 1; readReg2_D = 9;
    #1 chk("clear9", 32'(stall_D), 32'h0);
    chk("clear9_err", 32'(sbError), 32'h0);
    step("idle9");

    // Cancel releases the slot; a cancel against zero count is an error.
    setIdle(); issue_D = 1; destReg_D = 12;
    step("iss12");
    setIdle(); cancel_X = 1; cancelReg_X = 12;
    step("can12");
    setIdle(); useRs_D = 1; readReg1_D = 12;
    #1 chk("cancel_nostall", 32'(stall_D), 32'h0);
    step("dep12");
    setIdle(); cancel_X = 1; cancelReg_X = 12;
    step("can12z");
    setIdle();
    #1 chk("cancel_err", 32'(sbError), 32'h1);
    step("err1");
    step("err2");
    #1 chk("err_sticky", 32'(sbError), 32'h1);
    doReset();

    // Random traffic; writebacks and cancels mostly target pending registers.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      setIdle();
      readReg1_D = 5'($urandom_range(0, 7));
      readReg2_D = 5'($urandom_range(0, 7));
      useRs_D    = 1'($urandom_range(0, 1));
      useRt_D    = 1'($urandom_range(0, 1));
      issue_D    = ($urandom_range(0, 99) < 45);
      destReg_D  = 5'($urandom_range(0, 7));
      result_W   = $urandom();
      pendQ.delete();
      for (int r = 1; r < 32; r++) if (mCnt[r] > 0) pendQ.push_back(5'(r));
      if (pendQ.size() > 0 && $urandom_range(0, 99) < 55) begin
        regWrite_W = 1;
        writeReg_W = pendQ[$urandom_range(0, pendQ.size() - 1)];
      end else if ($urandom_range(0, 99) < 3) begin
        regWrite_W = 1;
        writeReg_W = 5'($urandom_range(0, 7));
      end
      if (pendQ.size() > 0 && $urandom_range(0, 99) < 12) begin
        cancel_X    = 1;
        cancelReg_X = pendQ[$urandom_range(0, pendQ.size() - 1)];
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
